vc_mem_lane_adapter: RTL and testbench

//  Connects a narrow processor mem port (P-bit data) to a wide memory port (M-bit data).

---
 rtl/vc_mem_lane_adapter_pkg.sv | 22 ++
 rtl/vc_mem_lane_tracker.sv | 76 +++++++
 rtl/vc_mem_lane_adapter.sv | 128 ++++++++++++
 tb/tb_vc_mem_lane_adapter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_mem_lane_adapter_pkg.sv
// Shared message-format helpers for the narrow/wide memory lane adapter.
// Each message is packed as {type, addr, len, data} for requests and {type, len, data} for responses.
package vc_mem_lane_adapter_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_e;

    function automatic int vc_mem_len_sz(input int data_sz);
        return $clog2(data_sz / 8);
    endfunction

    function automatic int vc_mem_req_msg_sz(input int addr_sz, input int data_sz);
        return 1 + addr_sz + vc_mem_len_sz(data_sz) + data_sz;
    endfunction

    function automatic int vc_mem_resp_msg_sz(input int data_sz);
        return 1 + vc_mem_len_sz(data_sz) + data_sz;
    endfunction

endpackage

// File: rtl/vc_mem_lane_tracker.sv
// In-order FIFO of per-request state.
// The head entry is visible combinationally so the response lane can be selected in the same cycle.
module vc_mem_lane_tracker #(
    parameter int p_entry_sz    = 8,
    parameter int p_num_entries = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq_val,
    output logic                  enq_rdy,
    input  logic [p_entry_sz-1:0] enq_msg,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [p_entry_sz-1:0] deq_msg
);

    localparam int PW = $clog2(p_num_entries);
    localparam int CW = PW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [p_entry_sz-1:0] entries_q [p_num_entries];
    logic [p_entry_sz-1:0] entries_d [p_num_entries];
    logic                  enq_fire_s;
    logic                  deq_fire_s;

    // A full tracker refuses enqueues even when the head leaves in the same cycle.
    assign enq_rdy    = (count_q != CW'(p_num_entries));
    assign deq_val    = (count_q != CW'(0));
    assign deq_msg    = entries_q[rd_ptr_q];
    assign enq_fire_s = enq_val & enq_rdy;
    assign deq_fire_s = deq_val & deq_rdy;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (enq_fire_s) begin
            entries_d[wr_ptr_q] = enq_msg;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deq_fire_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({enq_fire_s, deq_fire_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
            for (int i = 0; i < p_num_entries; i++) begin
                entries_q[i] <= p_entry_sz'(0);
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/vc_mem_lane_adapter.sv
// Adapts a narrow processor memory port to a wide memory port: reads become line reads,
// writes pass through zero-padded, and the response lane is picked using tracked request state.
module vc_mem_lane_adapter
    import vc_mem_lane_adapter_pkg::*;
#(
    parameter int p_addr_sz      = 32,
    parameter int p_proc_data_sz = 32,
    parameter int p_mem_data_sz  = 128,
    parameter int p_num_entries  = 4,
    parameter int p_line_reads   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic procreq_val,
    output logic procreq_rdy,
    input  logic [vc_mem_req_msg_sz(p_addr_sz, p_proc_data_sz)-1:0] procreq_msg,
    output logic procresp_val,
    input  logic procresp_rdy,
    output logic [vc_mem_resp_msg_sz(p_proc_data_sz)-1:0] procresp_msg,
    output logic memreq_val,
    input  logic memreq_rdy,
    output logic [vc_mem_req_msg_sz(p_addr_sz, p_mem_data_sz)-1:0] memreq_msg,
    input  logic memresp_val,
    output logic memresp_rdy,
    input  logic [vc_mem_resp_msg_sz(p_mem_data_sz)-1:0] memresp_msg
);

    localparam int A    = p_addr_sz;
    localparam int P    = p_proc_data_sz;
    localparam int M    = p_mem_data_sz;
    localparam int OFF  = $clog2(M / 8);
    localparam int PLEN = $clog2(P / 8);
    localparam int LW   = PLEN + 1;
    localparam int E    = 1 + OFF + PLEN;
    localparam int RQ   = vc_mem_req_msg_sz(A, P);
    localparam int RS   = vc_mem_resp_msg_sz(M);

    logic            req_type_s;
    logic [A-1:0]    req_addr_s;
    logic [PLEN-1:0] req_len_s;
    logic [P-1:0]    req_data_s;
    logic [LW-1:0]   req_nbytes_s;
    logic [A-1:0]    mreq_addr_s;
    logic [OFF-1:0]  mreq_len_s;
    logic [M-1:0]    mreq_data_s;
    logic [OFF-1:0]  enq_off_s;

    logic            trk_enq_rdy_s;
    logic            trk_deq_val_s;
    logic [E-1:0]    trk_head_s;
    logic            head_type_s;
    logic [OFF-1:0]  head_off_s;
    logic [PLEN-1:0] head_len_s;
    logic [LW-1:0]   head_nbytes_s;
    logic [P-1:0]    lane_s;
    logic [P-1:0]    resp_data_s;
    logic            unused_s;

    assign memreq_val   = procreq_val  & trk_enq_rdy_s & ~reset;
    assign procreq_rdy  = memreq_rdy   & trk_enq_rdy_s & ~reset;
    assign procresp_val = memresp_val  & trk_deq_val_s & ~reset;
    assign memresp_rdy  = procresp_rdy & trk_deq_val_s & ~reset;

    // Request unpack, address alignment and write padding.
    always_comb begin
        req_type_s   = procreq_msg[RQ-1];
        req_addr_s   = procreq_msg[RQ-2 -: A];
        req_len_s    = procreq_msg[P+PLEN-1:P];
        req_data_s   = procreq_msg[P-1:0];
        req_nbytes_s = (req_len_s == PLEN'(0)) ? LW'(P / 8) : {1'b0, req_len_s};
        mreq_addr_s  = req_addr_s;
        mreq_len_s   = OFF'(req_nbytes_s);
        mreq_data_s  = M'(0);
        enq_off_s    = req_addr_s[OFF-1:0];
        if (req_type_s == MEM_WRITE) begin
            mreq_data_s = M'(req_data_s);
            enq_off_s   = OFF'(0);
        end else if (p_line_reads != 0) begin
            mreq_addr_s[OFF-1:0] = OFF'(0);
            mreq_len_s           = OFF'(0);
        end else begin
            enq_off_s = OFF'(0);
        end
    end

    assign memreq_msg = {req_type_s, mreq_addr_s, mreq_len_s, mreq_data_s};

    vc_mem_lane_tracker #(
        .p_entry_sz    (E),
        .p_num_entries (p_num_entries)
    ) u_tracker (
        .clk     (clk),
        .reset   (reset),
        .enq_val (memreq_val & memreq_rdy),
        .enq_rdy (trk_enq_rdy_s),
        .enq_msg ({req_type_s, enq_off_s, req_len_s}),
        .deq_val (trk_deq_val_s),
        .deq_rdy (procresp_val & procresp_rdy),
        .deq_msg (trk_head_s)
    );

    // Response lane extraction; bytes past the requested length read as zero.
    always_comb begin
        head_type_s   = trk_head_s[E-1];
        head_off_s    = trk_head_s[E-2 -: OFF];
        head_len_s    = trk_head_s[PLEN-1:0];
        head_nbytes_s = (head_len_s == PLEN'(0)) ? LW'(P / 8) : {1'b0, head_len_s};
        lane_s        = P'(memresp_msg[M-1:0] >> {head_off_s, 3'b000});
        resp_data_s   = P'(0);
        if (head_type_s == MEM_READ) begin
            for (int i = 0; i < P / 8; i++) begin
                if (LW'(i) < head_nbytes_s) begin
                    resp_data_s[8*i +: 8] = lane_s[8*i +: 8];
                end else begin
                    resp_data_s[8*i +: 8] = 8'h00;
                end
            end
        end else begin
            resp_data_s = P'(0);
        end
    end

    assign procresp_msg = {head_type_s, head_len_s, resp_data_s};

    // Memory-side type/len are superseded by the tracker head.
    assign unused_s = ^memresp_msg[RS-1:M];

endmodule

// File: tb/tb_vc_mem_lane_adapter.sv
// Directed self-checking bench for vc_mem_lane_adapter (A=32, P=32, M=128, depth 4, line reads).
module tb_vc_mem_lane_adapter;

    localparam logic [127:0] LINE = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    logic         clk;
    logic         reset;
    logic         procreq_val, procreq_rdy;
    logic [66:0]  procreq_msg;
    logic         procresp_val, procresp_rdy;
    logic [34:0]  procresp_msg;
    logic         memreq_val, memreq_rdy;
    logic [164:0] memreq_msg;
    logic         memresp_val, memresp_rdy;
    logic [132:0] memresp_msg;

    int n_cmp = 0;
    int n_bad = 0;

    vc_mem_lane_adapter #(
        .p_addr_sz      (32),
        .p_proc_data_sz (32),
        .p_mem_data_sz  (128),
        .p_num_entries  (4),
        .p_line_reads   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .procreq_val  (procreq_val),
        .procreq_rdy  (procreq_rdy),
        .procreq_msg  (procreq_msg),
        .procresp_val (procresp_val),
        .procresp_rdy (procresp_rdy),
        .procresp_msg (procresp_msg),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memreq_msg   (memreq_msg),
        .memresp_val  (memresp_val),
        .memresp_rdy  (memresp_rdy),
        .memresp_msg  (memresp_msg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [66:0] mk_preq(input logic t, input logic [31:0] a,
                                            input logic [1:0] l, input logic [31:0] d);
        return {t, a, l, d};
    endfunction

    function automatic logic [164:0] mk_mreq(input logic t, input logic [31:0] a,
                                             input logic [3:0] l, input logic [127:0] d);
        return {t, a, l, d};
    endfunction

    function automatic logic [132:0] mk_mresp(input logic t, input logic [3:0] l,
                                              input logic [127:0] d);
        return {t, l, d};
    endfunction

    function automatic logic [34:0] mk_presp(input logic t, input logic [1:0] l,
                                             input logic [31:0] d);
        return {t, l, d};
    endfunction

    task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input string tag, input logic [66:0] m, input logic [164:0] exp_mreq);
        procreq_val = 1'b1;
        procreq_msg = m;
        #1;
        check_eq({tag, ".rdy"}, procreq_rdy, 1'b1);
        check_eq({tag, ".mreq"}, memreq_msg, exp_mreq);
        tick();
        procreq_val = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [132:0] mr, input logic [34:0] exp_presp);
        memresp_val  = 1'b1;
        memresp_msg  = mr;
        procresp_rdy = 1'b1;
        #1;
        check_eq({tag, ".val"}, procresp_val, 1'b1);
        check_eq({tag, ".presp"}, procresp_msg, exp_presp);
        tick();
        memresp_val = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        procreq_val  = 1'b1;
        memreq_rdy   = 1'b1;
        memresp_val  = 1'b1;
        procresp_rdy = 1'b1;
        #1;
        check_eq({tag, ".memreq_val"},   memreq_val,   1'b0);
        check_eq({tag, ".procresp_val"}, procresp_val, 1'b0);
        check_eq({tag, ".procreq_rdy"},  procreq_rdy,  1'b0);
        check_eq({tag, ".memresp_rdy"},  memresp_rdy,  1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        procreq_val  = 1'b0;
        procreq_msg  = 67'd0;
        procresp_rdy = 1'b0;
        memreq_rdy   = 1'b1;
        memresp_val  = 1'b0;
        memresp_msg  = mk_mresp(1'b0, 4'd0, LINE);

        // Reset behaviour
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        reset       = 1'b0;
        procreq_val = 1'b0;
        #1;
        check_eq("rst_rel.procreq_rdy",  procreq_rdy,  1'b1);
        check_eq("rst_rel.procresp_val", procresp_val, 1'b0);
        check_eq("rst_rel.memresp_rdy",  memresp_rdy,  1'b0);
        memresp_val  = 1'b0;
        procresp_rdy = 1'b0;

        // T1: aligned word read
        send_req("t1", mk_preq(1'b0, 32'h1008, 2'd0, 32'd0), mk_mreq(1'b0, 32'h1000, 4'd0, 128'd0));
        get_resp("t1", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd0, 32'hCCCCCCCC));

        // T2: single-byte read at offset 13
        send_req("t2", mk_preq(1'b0, 32'h100D, 2'd1, 32'd0), mk_mreq(1'b0, 32'h1000, 4'd0, 128'd0));
        get_resp("t2", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd1, 32'h000000DD));

        // T3: write pass-through and zero-data write response
        send_req("t3", mk_preq(1'b1, 32'h2004, 2'd0, 32'hDEADBEEF),
                 mk_mreq(1'b1, 32'h2004, 4'd4, {96'd0, 32'hDEADBEEF}));
        get_resp("t3", mk_mresp(1'b1, 4'd0, {128{1'b1}}), mk_presp(1'b1, 2'd0, 32'd0));

        // T4: fill the tracker, then drain in order
        send_req("t4a", mk_preq(1'b0, 32'h10, 2'd0, 32'd0), mk_mreq(1'b0, 32'h10, 4'd0, 128'd0));
        send_req("t4b", mk_preq(1'b0, 32'h24, 2'd0, 32'd0), mk_mreq(1'b0, 32'h20, 4'd0, 128'd0));
        send_req("t4c", mk_preq(1'b0, 32'h38, 2'd0, 32'd0), mk_mreq(1'b0, 32'h30, 4'd0, 128'd0));
        send_req("t4d", mk_preq(1'b0, 32'h4C, 2'd0, 32'd0), mk_mreq(1'b0, 32'h40, 4'd0, 128'd0));
        procreq_val = 1'b1;
        procreq_msg = mk_preq(1'b0, 32'h50, 2'd0, 32'd0);
        #1;
        check_eq("t4.full_rdy", procreq_rdy, 1'b0);
        check_eq("t4.full_val", memreq_val,  1'b0);
        memresp_val  = 1'b1;
        memresp_msg  = mk_mresp(1'b0, 4'd0, LINE);
        procresp_rdy = 1'b1;
        #1;
        check_eq("t4.full_deq_rdy", procreq_rdy, 1'b0);
        check_eq("t4.r0", procresp_msg, mk_presp(1'b0, 2'd0, 32'hAAAAAAAA));
        tick();
        procreq_val  = 1'b0;
        memresp_val  = 1'b0;
        procresp_rdy = 1'b0;
        #1;
        check_eq("t4.rdy_after_drain", procreq_rdy, 1'b1);
        get_resp("t4.r1", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd0, 32'hBBBBBBBB));
        get_resp("t4.r2", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd0, 32'hCCCCCCCC));
        get_resp("t4.r3", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd0, 32'hDDDDDDDD));
        procresp_rdy = 1'b0;
        #1;
        check_eq("t4.empty", procresp_val, 1'b0);

        // T5: simultaneous enqueue and dequeue keeps occupancy
        send_req("t5a", mk_preq(1'b0, 32'h100, 2'd0, 32'd0), mk_mreq(1'b0, 32'h100, 4'd0, 128'd0));
        send_req("t5b", mk_preq(1'b0, 32'h104, 2'd0, 32'd0), mk_mreq(1'b0, 32'h100, 4'd0, 128'd0));
        procreq_val  = 1'b1;
        procreq_msg  = mk_preq(1'b0, 32'h108, 2'd0, 32'd0);
        memresp_val  = 1'b1;
        memresp_msg  = mk_mresp(1'b0, 4'd0, LINE);
        procresp_rdy = 1'b1;
        #1;
        check_eq("t5.both_rdy", procreq_rdy, 1'b1);
        check_eq("t5.both_resp", procresp_msg, mk_presp(1'b0, 2'd0, 32'hAAAAAAAA));
        tick();
        procreq_val  = 1'b0;
        memresp_val  = 1'b0;
        procresp_rdy = 1'b0;
        send_req("t5d", mk_preq(1'b0, 32'h10C, 2'd0, 32'd0), mk_mreq(1'b0, 32'h100, 4'd0, 128'd0));
        send_req("t5e", mk_preq(1'b0, 32'h100, 2'd0, 32'd0), mk_mreq(1'b0, 32'h100, 4'd0, 128'd0));
        procreq_val = 1'b1;
        #1;
        check_eq("t5.full", procreq_rdy, 1'b0);
        procreq_val  = 1'b0;
        memresp_val  = 1'b1;
        procresp_rdy = 1'b0;
        #1;
        check_eq("t5.stall_mrdy", memresp_rdy,  1'b0);
        check_eq("t5.stall_val",  procresp_val, 1'b1);
        check_eq("t5.stall_msg0", procresp_msg, mk_presp(1'b0, 2'd0, 32'hBBBBBBBB));
        tick();
        check_eq("t5.stall_msg1", procresp_msg, mk_presp(1'b0, 2'd0, 32'hBBBBBBBB));
        get_resp("t5.r1", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd0, 32'hBBBBBBBB));
        get_resp("t5.r2", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd0, 32'hCCCCCCCC));
        get_resp("t5.r3", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd0, 32'hDDDDDDDD));
        get_resp("t5.r4", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd0, 32'hAAAAAAAA));
        procresp_rdy = 1'b0;

        // T6: reset drops outstanding requests
        send_req("t6a", mk_preq(1'b0, 32'h200, 2'd0, 32'd0), mk_mreq(1'b0, 32'h200, 4'd0, 128'd0));
        send_req("t6b", mk_preq(1'b0, 32'h204, 2'd0, 32'd0), mk_mreq(1'b0, 32'h200, 4'd0, 128'd0));
        send_req("t6c", mk_preq(1'b0, 32'h208, 2'd0, 32'd0), mk_mreq(1'b0, 32'h200, 4'd0, 128'd0));
        reset = 1'b1;
        check_reset_outputs("t6.rst");
        tick();
        reset       = 1'b0;
        procreq_val = 1'b0;
        #1;
        check_eq("t6.empty_val",  procresp_val, 1'b0);
        check_eq("t6.empty_mrdy", memresp_rdy,  1'b0);
        memresp_val  = 1'b0;
        procresp_rdy = 1'b0;
        send_req("t6d", mk_preq(1'b0, 32'h304, 2'd0, 32'd0), mk_mreq(1'b0, 32'h300, 4'd0, 128'd0));
        send_req("t6e", mk_preq(1'b0, 32'h300, 2'd0, 32'd0), mk_mreq(1'b0, 32'h300, 4'd0, 128'd0));
        send_req("t6f", mk_preq(1'b0, 32'h308, 2'd0, 32'd0), mk_mreq(1'b0, 32'h300, 4'd0, 128'd0));
        send_req("t6g", mk_preq(1'b0, 32'h30C, 2'd0, 32'd0), mk_mreq(1'b0, 32'h300, 4'd0, 128'd0));
        procreq_val = 1'b1;
        #1;
        check_eq("t6.full", procreq_rdy, 1'b0);
        procreq_val = 1'b0;
        get_resp("t6.r0", mk_mresp(1'b0, 4'd0, LINE), mk_presp(1'b0, 2'd0, 32'hBBBBBBBB));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
